// File: rtl/mandel_pixel_dispatcher.sv
// Frame walker for one Mandelbrot solver: launches each pixel,
// collects its iteration count and writes an RGB332 pixel.
module mandel_pixel_dispatcher #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int AW     = 19
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [26:0]   x_start,
  input  logic [26:0]   y_start,
  input  logic [26:0]   dx,
  input  logic [26:0]   dy,
  input  logic [12:0]   max_iter,
  output logic          solver_start,
  output logic [26:0]   solver_cr,
  output logic [26:0]   solver_ci,
  output logic [12:0]   solver_max,
  input  logic [12:0]   solver_iter,
  input  logic          solver_done,
  output logic          wr_valid,
  input  logic          wr_ready,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy,
  output logic          frame_done,
  output logic [31:0]   frame_cycles
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_GUARD,
    S_WAIT,
    S_WRITE,
    S_ADVANCE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          w_last;
  logic          w_finish;
  logic          w_hs;

  logic [26:0]   r_xs;
  logic [26:0]   r_dx;
  logic [26:0]   r_dy;
  logic [12:0]   r_max;
  logic [26:0]   r_cr;
  logic [26:0]   r_ci;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_data;
  logic          r_abort_pend;
  logic [31:0]   r_cycles;
  logic          r_done;

  // Iteration count to RGB332; escaped-at-limit is black,
  // and a colour that would alias to black is nudged to 1.
  function automatic logic [7:0] f_colour(
    input logic [12:0] it,
    input logic [12:0] mx
  );
    logic [7:0] c;
    c = {it[2:0], it[5:3], it[7:6]};
    if (it >= mx) begin
      return 8'h00;
    end
    if (c == 8'h00) begin
      return 8'h01;
    end
    return c;
  endfunction

  assign w_last   = (r_x == X_LAST) && (r_y == Y_LAST);
  assign w_hs     = (r_state == S_WRITE) && wr_ready;
  assign w_finish = (r_state != S_IDLE) && (w_next == S_IDLE);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: abort exits at once except mid-handshake
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_next = abort ? S_IDLE : S_GUARD;
      end
      S_GUARD: begin
        w_next = abort ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (solver_done) begin
          w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        if (wr_ready) begin
          if (abort || r_abort_pend) begin
            w_next = S_IDLE;
          end else begin
            w_next = S_ADVANCE;
          end
        end
      end
      S_ADVANCE: begin
        if (abort || w_last) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_LAUNCH;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Frame setup on start, raster step between pixels
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_xs   <= '0;
      r_dx   <= '0;
      r_dy   <= '0;
      r_max  <= '0;
      r_cr   <= '0;
      r_ci   <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_xs   <= x_start;
      r_dx   <= dx;
      r_dy   <= dy;
      r_max  <= max_iter;
      r_cr   <= x_start;
      r_ci   <= y_start;
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
    end else if (r_state == S_ADVANCE &&
                 w_next == S_LAUNCH) begin
      r_addr <= r_addr + AW'(1);
      if (r_x != X_LAST) begin
        r_x  <= r_x + XW'(1);
        r_cr <= r_cr + r_dx;
      end else begin
        r_x  <= '0;
        r_cr <= r_xs;
        r_y  <= r_y + YW'(1);
        r_ci <= r_ci - r_dy;
      end
    end
  end

  // Colour is fixed when the solver reports done
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data <= '0;
    end else if (r_state == S_WAIT &&
                 w_next == S_WRITE) begin
      r_data <= f_colour(solver_iter, r_max);
    end
  end

  // Abort seen during a stalled write ends the frame after it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_abort_pend <= 1'b0;
    end else if (r_state == S_IDLE || w_hs) begin
      r_abort_pend <= 1'b0;
    end else if (r_state == S_WRITE && abort) begin
      r_abort_pend <= 1'b1;
    end
  end

  // Busy-cycle counter and end-of-frame pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycles <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (r_state == S_IDLE) begin
        if (start) begin
          r_cycles <= '0;
        end
      end else if (r_cycles != 32'hFFFF_FFFF) begin
        r_cycles <= r_cycles + 32'd1;
      end
    end
  end

  assign solver_start = (r_state == S_LAUNCH);
  assign wr_valid     = (r_state == S_WRITE);
  assign busy         = (r_state != S_IDLE);
  assign solver_cr    = r_cr;
  assign solver_ci    = r_ci;
  assign solver_max   = r_max;
  assign wr_addr      = r_addr;
  assign wr_data      = r_data;
  assign frame_done   = r_done;
  assign frame_cycles = r_cycles;

endmodule

// File: tb/tb_mandel_pixel_dispatcher.sv
// Bench for mandel_pixel_dispatcher on a 4x3 grid with a
// behavioural solver that finishes 5 cycles after its start pulse.
module tb_mandel_pixel_dispatcher;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 4;
  localparam int MX = 1000;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [26:0]   x_start;
  logic [26:0]   y_start;
  logic [26:0]   dx;
  logic [26:0]   dy;
  logic [12:0]   max_iter;
  logic          solver_start;
  logic [26:0]   solver_cr;
  logic [26:0]   solver_ci;
  logic [12:0]   solver_max;
  logic [12:0]   solver_iter;
  logic          solver_done;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;
  logic          frame_done;
  logic [31:0]   frame_cycles;

  always #5 clk = ~clk;

  mandel_pixel_dispatcher #(
    .WIDTH (W),
    .HEIGHT(H),
    .AW    (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .x_start     (x_start),
    .y_start     (y_start),
    .dx          (dx),
    .dy          (dy),
    .max_iter    (max_iter),
    .solver_start(solver_start),
    .solver_cr   (solver_cr),
    .solver_ci   (solver_ci),
    .solver_max  (solver_max),
    .solver_iter (solver_iter),
    .solver_done (solver_done),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_cycles(frame_cycles)
  );

  // Solver model: done is a level that clears on the start
  // pulse; stale mode keeps an old done high for one more cycle.
  bit          stale;
  logic [12:0] m_next;
  logic [12:0] m_iter;
  logic [2:0]  m_cnt;
  logic        m_act;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_act  <= 1'b0;
      m_cnt  <= '0;
      m_iter <= '0;
    end else if (solver_start) begin
      m_act  <= 1'b1;
      m_cnt  <= 3'd5;
      m_iter <= m_next;
    end else if (m_cnt != 3'd0) begin
      m_cnt <= m_cnt - 3'd1;
    end
  end

  assign solver_done = m_act &&
    (m_cnt == 3'd0 || (stale && m_cnt == 3'd5));
  assign solver_iter = (stale && m_cnt == 3'd5) ?
    13'd77 : m_iter;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  tab[12] = '{1000, 9, 0, 5, 100, 300,
                   999, 12, 63, 1000, 256, 7};

  int cfg_n_exp;
  int cfg_stall_pix;
  int cfg_stall_len;
  int cfg_abort_wait;
  int cfg_abort_wr;
  int cfg_rst_pix;
  int last_cycles;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] colour(input int it,
                                        input int mx);
    logic [12:0] v;
    logic [7:0]  c;
    v = 13'(it);
    if (it >= mx) return 8'h00;
    c = {v[2:0], v[5:3], v[7:6]};
    return (c == 8'h00) ? 8'h01 : c;
  endfunction

  task automatic chk_zero(input string nm);
    chk({nm, "_sstart"}, 32'(solver_start), 0);
    chk({nm, "_wvalid"}, 32'(wr_valid), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_fdone"}, 32'(frame_done), 0);
    chk({nm, "_cr"}, 32'(solver_cr), 0);
    chk({nm, "_ci"}, 32'(solver_ci), 0);
    chk({nm, "_max"}, 32'(solver_max), 0);
    chk({nm, "_addr"}, 32'(wr_addr), 0);
    chk({nm, "_data"}, 32'(wr_data), 0);
    chk({nm, "_cyc"}, frame_cycles, 0);
  endtask

  task automatic cfg_default();
    cfg_n_exp      = 12;
    cfg_stall_pix  = 99;
    cfg_stall_len  = 0;
    cfg_abort_wait = 99;
    cfg_abort_wr   = 99;
    cfg_rst_pix    = 99;
  endtask

  task automatic run_frame(input string nm);
    int since;
    int stall;
    int launches;
    int writes;
    bit fin;
    bit rst_hit;
    logic [AW-1:0] haddr;
    logic [7:0]    hdata;
    logic [26:0]   ecr;
    logic [26:0]   eci;
    wr_t e;
    since = 0; stall = 0; launches = 0; writes = 0;
    fin = 0; rst_hit = 0; haddr = '0; hdata = '0;
    for (int p = 0; p < cfg_n_exp; p++) begin
      e.addr = AW'(p);
      e.data = colour(tab[p], MX);
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      abort    = 1'b0;
      wr_ready = 1'b1;
      since++;
      if (solver_start) begin
        ecr = x_start + 27'(launches % W) * dx;
        eci = y_start - 27'(launches / W) * dy;
        chk({nm, "_cr"}, 32'(solver_cr), 32'(ecr));
        chk({nm, "_ci"}, 32'(solver_ci), 32'(eci));
        chk({nm, "_max"}, 32'(solver_max), MX);
        if (launches == 5 && cfg_n_exp == 12) begin
          chk({nm, "_cr_px5"}, 32'(solver_cr),
              32'h7400000);
          chk({nm, "_ci_px5"}, 32'(solver_ci),
              32'h0400000);
        end
        m_next = 13'(tab[launches]);
        launches++;
        since = 0;
      end
      if (cfg_abort_wait == launches - 1 && since == 2)
        abort = 1'b1;
      if (cfg_rst_pix == launches - 1 && since == 3) begin
        #2 reset = 1'b0;
        #1;
        chk_zero({nm, "_rst"});
        chk({nm, "_rst_writes"}, writes, cfg_rst_pix);
        sb.delete();
        rst_hit = 1;
        fin = 1;
      end else if (frame_done) begin
        chk({nm, "_busy_end"}, 32'(busy), 0);
        last_cycles = int'(frame_cycles);
        fin = 1;
      end else begin
        if (wr_valid) begin
          if (writes == cfg_stall_pix &&
              stall < cfg_stall_len) begin
            wr_ready = 1'b0;
            chk({nm, "_stall_addr"}, 32'(wr_addr),
                cfg_stall_pix);
            if (stall == 0) begin
              haddr = wr_addr;
              hdata = wr_data;
            end else begin
              chk({nm, "_hold_addr"}, 32'(wr_addr),
                  32'(haddr));
              chk({nm, "_hold_data"}, 32'(wr_data),
                  32'(hdata));
            end
            stall++;
            if (writes == cfg_abort_wr && stall == 2)
              abort = 1'b1;
          end
          if (wr_ready) begin
            if (sb.size() == 0) begin
              chk({nm, "_extra_write"}, 1, 0);
            end else begin
              e = sb.pop_front();
              chk({nm, "_addr"}, 32'(wr_addr),
                  32'(e.addr));
              chk({nm, "_data"}, 32'(wr_data),
                  32'(e.data));
            end
            if (writes == 0 && cfg_n_exp == 12)
              chk({nm, "_px0_black"}, 32'(wr_data), 0);
            if (writes == 2 && cfg_n_exp == 12)
              chk({nm, "_px2_one"}, 32'(wr_data), 1);
            writes++;
          end
        end
        @(negedge clk);
      end
    end
    abort    = 1'b0;
    wr_ready = 1'b1;
    chk({nm, "_timeout"}, 32'(fin), 1);
    if (!rst_hit) begin
      chk({nm, "_writes"}, writes, cfg_n_exp);
      chk({nm, "_sb_left"}, sb.size(), 0);
      @(negedge clk);
      chk({nm, "_fdone_pulse"}, 32'(frame_done), 0);
      chk({nm, "_cyc_held"}, frame_cycles,
          32'(last_cycles));
    end
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    wr_ready = 1'b1;
    x_start  = 27'h7000000;
    y_start  = 27'h0800000;
    dx       = 27'h0400000;
    dy       = 27'h0400000;
    max_iter = 13'(MX);
    stale    = 0;
    m_next   = '0;
    last_cycles = 0;
    cfg_default();
    #3;
    chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    cfg_default();
    run_frame("A");
    chk("A_cycles", 32'(last_cycles), 108);

    cfg_default();
    cfg_stall_pix = 2;
    cfg_stall_len = 7;
    run_frame("B");
    chk("B_cycles", 32'(last_cycles), 115);

    cfg_default();
    stale = 1;
    run_frame("C");
    chk("C_cycles", 32'(last_cycles), 108);
    stale = 0;

    cfg_default();
    cfg_abort_wait = 6;
    cfg_n_exp      = 6;
    run_frame("D");
    chk("D_cycles", 32'(last_cycles), 57);

    cfg_default();
    cfg_stall_pix = 3;
    cfg_stall_len = 4;
    cfg_abort_wr  = 3;
    cfg_n_exp     = 4;
    run_frame("E");
    chk("E_cycles", 32'(last_cycles), 39);

    cfg_default();
    cfg_rst_pix = 4;
    run_frame("F");
    @(negedge clk);
    @(negedge clk);
    chk_zero("F_held");
    reset = 1'b1;

    cfg_default();
    run_frame("G");
    chk("G_cycles", 32'(last_cycles), 108);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
